// File: rtl/tt_sweep_capture.sv
// Sweeps all 128 vectors of a 7-input function and captures its truth table.
// Optional onset counter output enabled by defining ONSET_COUNT_EN.
module tt_sweep_capture #(
    parameter int SAMPLE_LAT = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [127:0] expected,
    output logic [6:0]   x,
    input  logic         f_in,
    output logic         busy,
    output logic         done,
    output logic [127:0] tt,
`ifdef ONSET_COUNT_EN
    output logic [7:0]   onset_cnt,
`endif
    output logic         match
);

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DRAIN
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [127:0]   r_exp;
    logic [127:0]   r_tt;
    logic [127:0]   w_tt_upd;
    logic [6:0]     r_x;
    logic           r_done;
    logic           r_match;
    logic           w_cap_v;
    logic [6:0]     w_cap_idx;
    logic           w_accept;
    logic           w_kill;
    logic           w_last;
`ifdef ONSET_COUNT_EN
    logic [7:0]     r_onset;
`endif

    assign w_accept = (r_state == IDLE) && start && !abort;
    assign w_kill   = (r_state != IDLE) && abort;
    assign w_last   = w_cap_v && (w_cap_idx == 7'd127);

    // Capture point: the vector presented SAMPLE_LAT cycles ago.
    generate
        if (SAMPLE_LAT == 0) begin : g_nodly
            assign w_cap_v   = (r_state == SWEEP);
            assign w_cap_idx = r_x;
        end else begin : g_dly
            logic [SAMPLE_LAT-1:0] r_pv;
            logic [6:0]            r_pi [SAMPLE_LAT];

            always_ff @(posedge clk) begin
                if (!rst_n || w_kill) begin
                    r_pv <= '0;
                end else begin
                    r_pv[0] <= (r_state == SWEEP);
                    for (int i = 1; i < SAMPLE_LAT; i++) begin
                        r_pv[i] <= r_pv[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                r_pi[0] <= r_x;
                for (int i = 1; i < SAMPLE_LAT; i++) begin
                    r_pi[i] <= r_pi[i-1];
                end
            end

            assign w_cap_v   = r_pv[SAMPLE_LAT-1];
            assign w_cap_idx = r_pi[SAMPLE_LAT-1];
        end
    endgenerate

    always_comb begin
        w_tt_upd = r_tt;
        if (w_cap_v) begin
            w_tt_upd[w_cap_idx] = f_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) w_state_nxt = SWEEP;
            end
            SWEEP: begin
                if (w_last) w_state_nxt = IDLE;
                else if (r_x == 7'd127) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (w_last) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_kill) w_state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_exp   <= '0;
            r_tt    <= '0;
            r_x     <= '0;
            r_done  <= 1'b0;
            r_match <= 1'b0;
`ifdef ONSET_COUNT_EN
            r_onset <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_kill) begin
                r_x     <= '0;
                r_tt    <= '0;
                r_match <= 1'b0;
`ifdef ONSET_COUNT_EN
                r_onset <= '0;
`endif
            end else if (w_accept) begin
                r_exp   <= expected;
                r_x     <= '0;
                r_tt    <= '0;
                r_match <= 1'b0;
`ifdef ONSET_COUNT_EN
                r_onset <= '0;
`endif
            end else begin
                if (r_state == SWEEP && r_x != 7'd127) begin
                    r_x <= r_x + 7'd1;
                end
                if (w_cap_v) begin
                    r_tt <= w_tt_upd;
`ifdef ONSET_COUNT_EN
                    r_onset <= r_onset + {7'd0, f_in};
`endif
                end
                if (w_last) begin
                    r_x     <= '0;
                    r_done  <= 1'b1;
                    r_match <= (w_tt_upd == r_exp);
                end
            end
        end
    end

    assign x     = r_x;
    assign busy  = (r_state != IDLE);
    assign done  = r_done;
    assign tt    = r_tt;
    assign match = r_match;
`ifdef ONSET_COUNT_EN
    assign onset_cnt = r_onset;
`endif

endmodule
